// File: rtl/mem_stage_if.sv
// Bus between the M pipeline register, the memory stage and the W/forwarding side.
// Includes the debug preload port used to seed data memory.
interface mem_stage_if;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        dbg_we;
  logic [63:0] dbg_addr;
  logic [63:0] dbg_wdata;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        mem_busy;

  modport master (
    output M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM,
    output dbg_we, dbg_addr, dbg_wdata,
    input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, mem_busy
  );

  modport slave (
    input  M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM,
    input  dbg_we, dbg_addr, dbg_wdata,
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, mem_busy
  );
endinterface

// File: rtl/mem_stage.sv
// Y86-64 memory stage: multi-cycle quadword loads/stores against a little-endian byte memory,
// stalling the pipeline through mem_busy while an access is in flight.
module mem_stage #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input logic      clk,
  input logic      rst_n,
  mem_stage_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
  // The IDLE cycle that accepts the op is the first busy cycle, so BUSY lasts LATENCY-1 cycles.
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd3;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   valm_reg;
  logic [7:0]    mem [MEM_BYTES];

  logic        rd_op, wr_op, mem_op, addr_err, start, access, dbg_ok;
  logic [63:0] addr;

  // Instruction decode and address check
  always_comb begin
    rd_op    = (bus.M_icode == I_MRMOVQ) || (bus.M_icode == I_POPQ) || (bus.M_icode == I_RET);
    wr_op    = (bus.M_icode == I_RMMOVQ) || (bus.M_icode == I_PUSHQ) || (bus.M_icode == I_CALL);
    addr     = ((bus.M_icode == I_POPQ) || (bus.M_icode == I_RET)) ? bus.M_valA : bus.M_valE;
    mem_op   = (rd_op || wr_op) && (bus.M_stat == SAOK);
    addr_err = mem_op && (addr > ADDR_MAX);
    start    = mem_op && !addr_err;
    access   = ((state == S_BUSY) && (cnt == '0)) ||
               ((state == S_IDLE) && start && (LATENCY == 32'd1));
  end

  always_comb begin
    bus.m_icode  = bus.M_icode;
    bus.m_valE   = bus.M_valE;
    bus.m_dstE   = bus.M_dstE;
    bus.m_dstM   = bus.M_dstM;
    bus.m_stat   = addr_err ? SADR : bus.M_stat;
    bus.mem_busy = rst_n && ((state == S_BUSY) || ((state == S_IDLE) && start));
    bus.m_valM   = ((state == S_DONE) && rd_op) ? valm_reg : 64'd0;
    dbg_ok       = bus.dbg_we && (state == S_IDLE) && !bus.mem_busy && (bus.dbg_addr <= ADDR_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      valm_reg <= 64'd0;
    end else begin
      if (access && rd_op) begin
        for (int i = 0; i < 8; i++) begin
          valm_reg[8*i +: 8] <= mem[AW'(addr) + AW'(i)];
        end
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= CNT_LOAD;
            state <= (LATENCY == 32'd1) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - CW'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory contents survive reset; a store abandoned by reset never lands
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (access && wr_op) begin
        for (int i = 0; i < 8; i++) begin
          mem[AW'(addr) + AW'(i)] <= bus.M_valA[8*i +: 8];
        end
      end else if (dbg_ok) begin
        for (int i = 0; i < 8; i++) begin
          mem[AW'(bus.dbg_addr) + AW'(i)] <= bus.dbg_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboarded memory ops checked with immediate assertions.
module tb_mem_stage;
  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned LATENCY   = 2;

  localparam logic [3:0] I_NOP = 4'h1, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6,
                         I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [2:0] SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3;

  typedef struct {
    logic [2:0]  stat;
    logic [63:0] valm;
    int          busy;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  mem_stage_if bus ();

  mem_stage #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic neutral();
    bus.M_stat  = SAOK;
    bus.M_icode = I_NOP;
    bus.M_valE  = 64'd0;
    bus.M_valA  = 64'd0;
    bus.M_dstE  = 4'hF;
    bus.M_dstM  = 4'hF;
    bus.dbg_we  = 1'b0;
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    neutral();
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
    @(posedge clk); #1;
    bus.dbg_we = 1'b0;
  endtask

  // Drive one M-register op, push its expected result, then follow it until the non-busy cycle
  task automatic run_op(input string tag, input logic [2:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [2:0] exp_stat, input logic [63:0] exp_valm, input int exp_busy);
    exp_t e;
    int   busy;
    bit   done;
    e.stat = exp_stat; e.valm = exp_valm; e.busy = exp_busy;
    sb.push_back(e);
    bus.M_stat = st; bus.M_icode = ic; bus.M_valE = ve; bus.M_valA = va;
    bus.M_dstE = 4'h3; bus.M_dstM = 4'h7;
    busy = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_busy === 1'b1) begin
        busy++;
        chk({tag, ".valM_while_busy"}, bus.m_valM, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, ".busy_cycles"}, 64'(busy), 64'(e.busy));
        chk({tag, ".valM"}, bus.m_valM, e.valm);
        chk({tag, ".stat"}, 64'(bus.m_stat), 64'(e.stat));
        chk({tag, ".icode"}, 64'(bus.m_icode), 64'(ic));
        chk({tag, ".valE"}, bus.m_valE, ve);
        chk({tag, ".dst"}, 64'({bus.m_dstE, bus.m_dstM}), 64'h37);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      chk({tag, ".timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    neutral();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.dbg_addr  = 64'd0;
    bus.dbg_wdata = 64'd0;
    neutral();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 64'(bus.mem_busy), 64'd0);
    chk("reset.valM", bus.m_valM, 64'd0);
    chk("reset.stat", 64'(bus.m_stat), 64'(SAOK));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load
    preload(64'h10, 64'h0123456789ABCDEF);
    run_op("ld10", SAOK, I_MRMOVQ, 64'h10, 64'h0, SAOK, 64'h0123456789ABCDEF, LATENCY);

    // Store then straddling load shows byte order
    preload(64'h18, 64'h1111111111111111);
    run_op("st20", SAOK, I_RMMOVQ, 64'h20, 64'hDEADBEEF, SAOK, 64'd0, LATENCY);
    run_op("ld20", SAOK, I_MRMOVQ, 64'h20, 64'h0, SAOK, 64'h00000000DEADBEEF, LATENCY);
    run_op("ld1f", SAOK, I_MRMOVQ, 64'h1F, 64'h0, SAOK, 64'h000000DEADBEEF11, LATENCY);

    // Address boundary
    preload(64'(MEM_BYTES - 8), 64'hA5A5_5A5A_C3C3_3C3C);
    run_op("ld_top", SAOK, I_MRMOVQ, 64'(MEM_BYTES - 8), 64'h0, SAOK, 64'hA5A5_5A5A_C3C3_3C3C, LATENCY);
    run_op("ld_over", SAOK, I_MRMOVQ, 64'(MEM_BYTES - 7), 64'h0, SADR, 64'd0, 0);
    run_op("st_over", SAOK, I_RMMOVQ, 64'(MEM_BYTES - 7), 64'h7777, SADR, 64'd0, 0);
    run_op("st_huge", SAOK, I_RMMOVQ, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8888, SADR, 64'd0, 0);
    run_op("pop_huge", SAOK, I_POPQ, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, SADR, 64'd0, 0);
    run_op("ld_top2", SAOK, I_MRMOVQ, 64'(MEM_BYTES - 8), 64'h0, SAOK, 64'hA5A5_5A5A_C3C3_3C3C, LATENCY);

    // Non-memory ops pass straight through
    run_op("opq", SAOK, I_OPQ, 64'h1234, 64'h55, SAOK, 64'd0, 0);
    run_op("nop", SAOK, I_NOP, 64'h9999, 64'h0, SAOK, 64'd0, 0);

    // Non-AOK status suppresses the store
    preload(64'h40, 64'h4040404040404040);
    run_op("push_hlt", SHLT, I_PUSHQ, 64'h40, 64'h999, SHLT, 64'd0, 0);
    run_op("ld40", SAOK, I_MRMOVQ, 64'h40, 64'h0, SAOK, 64'h4040404040404040, LATENCY);

    // Stack ops: push/call address by valE, pop/ret by valA
    run_op("push48", SAOK, I_PUSHQ, 64'h48, 64'hCAFE_F00D, SAOK, 64'd0, LATENCY);
    run_op("pop48", SAOK, I_POPQ, 64'h50, 64'h48, SAOK, 64'hCAFE_F00D, LATENCY);
    run_op("call58", SAOK, I_CALL, 64'h58, 64'h0000_0000_0000_0123, SAOK, 64'd0, LATENCY);
    run_op("ret58", SAOK, I_RET, 64'h60, 64'h58, SAOK, 64'h0000_0000_0000_0123, LATENCY);

    // Reset on the last busy cycle of a store abandons it
    preload(64'h30, 64'h3030303030303030);
    bus.M_stat = SAOK; bus.M_icode = I_RMMOVQ; bus.M_valE = 64'h30; bus.M_valA = 64'hBAD;
    bus.M_dstE = 4'h3; bus.M_dstM = 4'hF;
    @(negedge clk);
    chk("rst.busy1", 64'(bus.mem_busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.busy2", 64'(bus.mem_busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst.busy_after", 64'(bus.mem_busy), 64'd0);
    chk("rst.valM_after", bus.m_valM, 64'd0);
    chk("rst.icode_pass", 64'(bus.m_icode), 64'(I_RMMOVQ));
    neutral();
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("ld30", SAOK, I_MRMOVQ, 64'h30, 64'h0, SAOK, 64'h3030303030303030, LATENCY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
